// File: rtl/one_conv_mac_accumulator.sv
// one_conv_mac_accumulator: 1x1-convolution MAC stage for 13 IFM lanes.
// Per beat: 13 pixels x one weight, accumulated over ifm_channel beats, then
// rounded, saturated to 16 bits and presented on a valid/ready output.
// Optional: define ONE_CONV_LEAKY_EN for a leaky-ReLU on negative outputs.
module one_conv_mac_accumulator #(
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [10:0]        ifm_channel,
  input  logic               conv1_ifm_valid,
  input  logic signed [15:0] conv1_ifm_data_0,
  input  logic signed [15:0] conv1_ifm_data_1,
  input  logic signed [15:0] conv1_ifm_data_2,
  input  logic signed [15:0] conv1_ifm_data_3,
  input  logic signed [15:0] conv1_ifm_data_4,
  input  logic signed [15:0] conv1_ifm_data_5,
  input  logic signed [15:0] conv1_ifm_data_6,
  input  logic signed [15:0] conv1_ifm_data_7,
  input  logic signed [15:0] conv1_ifm_data_8,
  input  logic signed [15:0] conv1_ifm_data_9,
  input  logic signed [15:0] conv1_ifm_data_10,
  input  logic signed [15:0] conv1_ifm_data_11,
  input  logic signed [15:0] conv1_ifm_data_12,
  input  logic               weight_valid,
  input  logic signed [15:0] weight_data,
  output logic               conv1_ifm_weight_hs,
  output logic               ofm_valid,
  input  logic               ofm_ready,
  output logic signed [15:0] ofm_data_0,
  output logic signed [15:0] ofm_data_1,
  output logic signed [15:0] ofm_data_2,
  output logic signed [15:0] ofm_data_3,
  output logic signed [15:0] ofm_data_4,
  output logic signed [15:0] ofm_data_5,
  output logic signed [15:0] ofm_data_6,
  output logic signed [15:0] ofm_data_7,
  output logic signed [15:0] ofm_data_8,
  output logic signed [15:0] ofm_data_9,
  output logic signed [15:0] ofm_data_10,
  output logic signed [15:0] ofm_data_11,
  output logic signed [15:0] ofm_data_12,
  output logic               ofm_busy
);

  localparam int unsigned LANES = 13;

  localparam logic [1:0] S_ACC    = 2'd0;
  localparam logic [1:0] S_FLUSH1 = 2'd1;
  localparam logic [1:0] S_FLUSH2 = 2'd2;
  localparam logic [1:0] S_OUT    = 2'd3;

  localparam logic signed [ACC_W:0] C_HALF = (ACC_W+1)'(2 ** (FRAC_BITS - 1));
  localparam logic signed [ACC_W:0] C_MAX  = (ACC_W+1)'(32767);
  localparam logic signed [ACC_W:0] C_MIN  = (ACC_W+1)'(-32768);

  logic [1:0]               r_state;
  logic [10:0]              r_ch_cnt;
  logic [10:0]              r_nch;
  logic [10:0]              w_nch;
  logic                     w_hs;
  logic                     w_last;
  logic                     w_ofm_hs;
  logic signed [15:0]       w_ifm   [LANES];
  logic signed [31:0]       r_prod  [LANES];
  logic                     r_prod_vld;
  logic signed [ACC_W-1:0]  r_acc   [LANES];
  logic signed [ACC_W:0]    w_rnd   [LANES];
  logic signed [ACC_W:0]    w_shr   [LANES];
  logic signed [15:0]       w_sat   [LANES];
  logic signed [15:0]       w_act   [LANES];
  logic signed [15:0]       r_ofm   [LANES];
  logic                     r_ofm_valid;

  assign w_ifm[0]  = conv1_ifm_data_0;
  assign w_ifm[1]  = conv1_ifm_data_1;
  assign w_ifm[2]  = conv1_ifm_data_2;
  assign w_ifm[3]  = conv1_ifm_data_3;
  assign w_ifm[4]  = conv1_ifm_data_4;
  assign w_ifm[5]  = conv1_ifm_data_5;
  assign w_ifm[6]  = conv1_ifm_data_6;
  assign w_ifm[7]  = conv1_ifm_data_7;
  assign w_ifm[8]  = conv1_ifm_data_8;
  assign w_ifm[9]  = conv1_ifm_data_9;
  assign w_ifm[10] = conv1_ifm_data_10;
  assign w_ifm[11] = conv1_ifm_data_11;
  assign w_ifm[12] = conv1_ifm_data_12;

  assign ofm_data_0  = r_ofm[0];
  assign ofm_data_1  = r_ofm[1];
  assign ofm_data_2  = r_ofm[2];
  assign ofm_data_3  = r_ofm[3];
  assign ofm_data_4  = r_ofm[4];
  assign ofm_data_5  = r_ofm[5];
  assign ofm_data_6  = r_ofm[6];
  assign ofm_data_7  = r_ofm[7];
  assign ofm_data_8  = r_ofm[8];
  assign ofm_data_9  = r_ofm[9];
  assign ofm_data_10 = r_ofm[10];
  assign ofm_data_11 = r_ofm[11];
  assign ofm_data_12 = r_ofm[12];

  // rst gates the handshake so nothing is reported consumed while in reset
  assign w_hs                = conv1_ifm_valid & weight_valid & (r_state == S_ACC) & ~rst;
  assign conv1_ifm_weight_hs = w_hs;
  assign ofm_valid           = r_ofm_valid;
  assign ofm_busy            = (r_state != S_ACC);
  assign w_ofm_hs            = r_ofm_valid & ofm_ready;

  // Channel count is taken live on the first beat, then frozen for the group
  assign w_nch  = (r_ch_cnt == '0) ? ((ifm_channel == '0) ? 11'd1 : ifm_channel) : r_nch;
  assign w_last = w_hs & (r_ch_cnt == (w_nch - 11'd1));

  // Group sequencing: count beats, then flush the two pipeline stages and wait for ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_ACC;
      r_ch_cnt <= '0;
      r_nch    <= 11'd1;
    end else begin
      case (r_state)
        S_ACC: begin
          if (w_hs) begin
            if (r_ch_cnt == '0) r_nch <= w_nch;
            if (w_last) begin
              r_ch_cnt <= '0;
              r_state  <= S_FLUSH1;
            end else begin
              r_ch_cnt <= r_ch_cnt + 11'd1;
            end
          end
        end
        S_FLUSH1: r_state <= S_FLUSH2;
        S_FLUSH2: r_state <= S_OUT;
        S_OUT:    if (w_ofm_hs) r_state <= S_ACC;
        default:  r_state <= S_ACC;
      endcase
    end
  end

  // Stage 1: register one full-precision product per lane on each handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod_vld <= 1'b0;
      for (int unsigned i = 0; i < LANES; i++) r_prod[i] <= '0;
    end else begin
      r_prod_vld <= w_hs;
      if (w_hs) begin
        for (int unsigned i = 0; i < LANES; i++)
          r_prod[i] <= 32'(w_ifm[i]) * 32'(weight_data);
      end
    end
  end

  // Stage 2: wide non-saturating accumulation, cleared once the result is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < LANES; i++) r_acc[i] <= '0;
    end else if (w_ofm_hs) begin
      for (int unsigned i = 0; i < LANES; i++) r_acc[i] <= '0;
    end else if (r_prod_vld) begin
      for (int unsigned i = 0; i < LANES; i++)
        r_acc[i] <= r_acc[i] + ACC_W'(r_prod[i]);
    end
  end

  // Round half up, rescale to the output Q-format, saturate, then optional activation
  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      w_rnd[i] = (ACC_W+1)'(r_acc[i]) + C_HALF;
      w_shr[i] = w_rnd[i] >>> FRAC_BITS;
      if (w_shr[i] > C_MAX)
        w_sat[i] = 16'sh7FFF;
      else if (w_shr[i] < C_MIN)
        w_sat[i] = 16'sh8000;
      else
        w_sat[i] = w_shr[i][15:0];
`ifdef ONE_CONV_LEAKY_EN
      w_act[i] = w_sat[i][15] ? ((w_sat[i] >>> 4) + (w_sat[i] >>> 5)) : w_sat[i];
`else
      w_act[i] = w_sat[i];
`endif
    end
  end

  // Output register: load in FLUSH2, hold until accepted; data persists afterwards
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ofm_valid <= 1'b0;
      for (int unsigned i = 0; i < LANES; i++) r_ofm[i] <= '0;
    end else if (r_state == S_FLUSH2) begin
      r_ofm_valid <= 1'b1;
      for (int unsigned i = 0; i < LANES; i++) r_ofm[i] <= w_act[i];
    end else if (w_ofm_hs) begin
      r_ofm_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_one_conv_mac_accumulator.sv
// Scoreboard bench for one_conv_mac_accumulator. Expected OFM lanes are
// computed from the driven beats and queued; the monitor pops on each
// output handshake. Build with ONE_CONV_LEAKY_EN to exercise the activation.
module tb_one_conv_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] ifm_channel;
  logic        conv1_ifm_valid;
  logic        weight_valid;
  logic [15:0] d [13];
  logic [15:0] weight_data;
  logic        hs;
  logic        ofm_valid;
  logic        ofm_ready;
  logic [15:0] o [13];
  logic        ofm_busy;

  always #5 clk = ~clk;

  one_conv_mac_accumulator #(.FRAC_BITS(8), .ACC_W(40)) dut (
    .clk(clk), .rst(rst), .ifm_channel(ifm_channel),
    .conv1_ifm_valid(conv1_ifm_valid),
    .conv1_ifm_data_0(d[0]),   .conv1_ifm_data_1(d[1]),   .conv1_ifm_data_2(d[2]),
    .conv1_ifm_data_3(d[3]),   .conv1_ifm_data_4(d[4]),   .conv1_ifm_data_5(d[5]),
    .conv1_ifm_data_6(d[6]),   .conv1_ifm_data_7(d[7]),   .conv1_ifm_data_8(d[8]),
    .conv1_ifm_data_9(d[9]),   .conv1_ifm_data_10(d[10]), .conv1_ifm_data_11(d[11]),
    .conv1_ifm_data_12(d[12]),
    .weight_valid(weight_valid), .weight_data(weight_data),
    .conv1_ifm_weight_hs(hs),
    .ofm_valid(ofm_valid), .ofm_ready(ofm_ready),
    .ofm_data_0(o[0]),   .ofm_data_1(o[1]),   .ofm_data_2(o[2]),
    .ofm_data_3(o[3]),   .ofm_data_4(o[4]),   .ofm_data_5(o[5]),
    .ofm_data_6(o[6]),   .ofm_data_7(o[7]),   .ofm_data_8(o[8]),
    .ofm_data_9(o[9]),   .ofm_data_10(o[10]), .ofm_data_11(o[11]),
    .ofm_data_12(o[12]),
    .ofm_busy(ofm_busy)
  );

  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  logic [207:0]  sb_q[$];
  logic [207:0]  exp_last;
  longint        m_acc [13];
  int            m_cnt = 0;
  int            m_nch = 1;
  int            first_hs = 0;
  int            last_hs = 0;
  bit            lat_armed = 1'b0;
  bit            prev_valid = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_out(input longint a);
    longint r;
    int     x;
    r = (a + 64'sd128) >>> 8;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    x = int'(r);
`ifdef ONE_CONV_LEAKY_EN
    if (x < 0) x = (x >>> 4) + (x >>> 5);
`endif
    return x[15:0];
  endfunction

  task automatic model_clear();
    m_cnt = 0;
    for (int i = 0; i < 13; i++) m_acc[i] = 0;
  endtask

  // Present one beat with current d[] and weight w; returns just after it is consumed
  task automatic send_beat(input logic [15:0] w);
    bit got;
    logic [207:0] e;
    if (m_cnt == 0) m_nch = (ifm_channel == 11'd0) ? 1 : int'(ifm_channel);
    weight_data     = w;
    conv1_ifm_valid = 1'b1;
    weight_valid    = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (hs) got = 1'b1;
    end
    if (!got) begin
      chk("hs_timeout", 32'd0, 32'd1);
      conv1_ifm_valid = 1'b0;
      weight_valid    = 1'b0;
      return;
    end
    if (m_cnt == 0) first_hs = cyc;
    for (int i = 0; i < 13; i++)
      m_acc[i] += longint'($signed(d[i])) * longint'($signed(w));
    m_cnt++;
    if (m_cnt == m_nch) begin
      for (int i = 0; i < 13; i++) e[i*16 +: 16] = model_out(m_acc[i]);
      sb_q.push_back(e);
      exp_last  = e;
      last_hs   = cyc;
      lat_armed = 1'b1;
      model_clear();
    end
    @(posedge clk); #1;
  endtask

  task automatic drop();
    conv1_ifm_valid = 1'b0;
    weight_valid    = 1'b0;
  endtask

  task automatic wait_valid();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (ofm_valid) seen = 1'b1;
    end
    if (!seen) chk("ofm_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < 13; i++) d[i] = v;
  endtask

  // Monitor: latency on each fresh result, scoreboard compare on each handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (ofm_valid && !prev_valid && lat_armed) begin
        chk("latency", 32'(cyc - last_hs), 32'd3);
        lat_armed = 1'b0;
      end
      if (ofm_valid && ofm_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_ofm", 32'd1, 32'd0);
        end else begin
          logic [207:0] e;
          e = sb_q.pop_front();
          for (int i = 0; i < 13; i++)
            chk($sformatf("ofm_lane%0d", i), 32'(o[i]), 32'(e[i*16 +: 16]));
        end
      end
    end
    prev_valid = ofm_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ifm_channel = 11'd1; ofm_ready = 1'b1;
    weight_data = '0; fill(16'h0000);
    conv1_ifm_valid = 1'b1; weight_valid = 1'b1;
    model_clear();
    @(negedge clk);
    chk("rst_hs", 32'(hs), 32'd0);
    chk("rst_valid", 32'(ofm_valid), 32'd0);
    chk("rst_busy", 32'(ofm_busy), 32'd0);
    for (int i = 0; i < 13; i++) chk($sformatf("rst_lane%0d", i), 32'(o[i]), 32'd0);
    drop();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Single valid alone must not handshake
    conv1_ifm_valid = 1'b1;
    @(negedge clk); chk("ifm_only_hs", 32'(hs), 32'd0);
    @(posedge clk); #1; conv1_ifm_valid = 1'b0; weight_valid = 1'b1;
    @(negedge clk); chk("wgt_only_hs", 32'(hs), 32'd0);
    @(posedge clk); #1; drop();

    // 1 channel, 1.0 x 2.0 -> 2.0; back in ACC the cycle after the handshake
    ifm_channel = 11'd1; fill(16'h0100);
    send_beat(16'h0200); drop();
    wait_valid();
    @(negedge clk);
    chk("back_to_acc_busy", 32'(ofm_busy), 32'd0);
    chk("back_to_acc_valid", 32'(ofm_valid), 32'd0);
    @(posedge clk); #1;

    // 4 channels, lane i = (i+1), weight 0.5 -> lane i = 2*(i+1), no bubbles
    ifm_channel = 11'd4;
    for (int i = 0; i < 13; i++) d[i] = 16'(16'h0100 * (i + 1));
    for (int b = 0; b < 4; b++) send_beat(16'h0080);
    drop();
    chk("no_bubble", 32'(last_hs - first_hs), 32'd3);
    chk("lane12_model", 32'(exp_last[12*16 +: 16]), 32'h1A00);
    wait_valid();
    @(posedge clk); #1;

    // Positive and negative saturation
    ifm_channel = 11'd2; fill(16'h7FFF);
    send_beat(16'h7FFF); send_beat(16'h7FFF); drop();
    wait_valid(); @(posedge clk); #1;
    send_beat(16'h8001); send_beat(16'h8001); drop();
    wait_valid(); @(posedge clk); #1;

    // Negative result (-4.0): linear or leaky depending on build
    ifm_channel = 11'd1; fill(16'h0100);
    send_beat(16'hFC00); drop();
    wait_valid(); @(posedge clk); #1;

    // Rounding at half-LSB for positive and negative lanes; ifm_channel 0 means 1
    ifm_channel = 11'd0;
    for (int i = 0; i < 13; i++) d[i] = 16'(i - 6);
    send_beat(16'h0080); drop();
    wait_valid(); @(posedge clk); #1;

    // ifm_channel change mid-group is ignored until the next group
    ifm_channel = 11'd3;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 13; i++) d[i] = 16'($urandom_range(0, 16'hFFFF));
      send_beat(16'($urandom_range(0, 16'hFFFF)));
      ifm_channel = 11'd1;
    end
    drop();
    wait_valid(); @(posedge clk); #1;

    // Random groups
    for (int g = 0; g < 3; g++) begin
      ifm_channel = 11'($urandom_range(1, 6));
      for (int b = 0; b < int'(ifm_channel); b++) begin
        for (int i = 0; i < 13; i++) d[i] = 16'($urandom_range(0, 16'hFFFF));
        send_beat(16'($urandom_range(0, 16'hFFFF)));
      end
      drop();
      wait_valid(); @(posedge clk); #1;
    end

    // Backpressure: result held, no handshake, busy, then clean next group
    ofm_ready = 1'b0; ifm_channel = 11'd2;
    for (int i = 0; i < 13; i++) d[i] = 16'(16'h0040 * (i + 1));
    send_beat(16'h0300); send_beat(16'hFF00); drop();
    wait_valid();
    @(posedge clk); #1;
    conv1_ifm_valid = 1'b1; weight_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_hs", 32'(hs), 32'd0);
      chk("bp_busy", 32'(ofm_busy), 32'd1);
      chk("bp_valid", 32'(ofm_valid), 32'd1);
      chk("bp_lane0", 32'(o[0]), 32'(exp_last[15:0]));
      chk("bp_lane12", 32'(o[12]), 32'(exp_last[12*16 +: 16]));
    end
    @(posedge clk); #1;
    drop(); ofm_ready = 1'b1;
    ifm_channel = 11'd1; fill(16'h0100);
    send_beat(16'h0100); drop();
    wait_valid(); @(posedge clk); #1;

    // Async reset after 2 of 4 channels; partial sums must not leak into the next group
    ifm_channel = 11'd4; fill(16'h1000);
    send_beat(16'h0400); send_beat(16'h0400);
    #3 rst = 1'b1;
    drop(); model_clear(); lat_armed = 1'b0;
    #1;
    chk("rstmid_valid", 32'(ofm_valid), 32'd0);
    chk("rstmid_busy", 32'(ofm_busy), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(ofm_valid), 32'd0);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 13; i++) d[i] = 16'(16'h0010 * (i + 1));
    for (int b = 0; b < 4; b++) send_beat(16'h0100);
    drop();
    wait_valid(); @(posedge clk); #1;

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
